// File: rtl/axi_rd_master.sv
`default_nettype none
// ============================================================================
// axi_rd_master : single-outstanding AXI4 read initiator with per-beat
//                 RID/RLAST checking and idle timeout.      Rev 1.0
// ============================================================================
module axi_rd_master #(
  parameter int TAGW    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic            aclk,
  input  logic            rst_l,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [31:0]     cmd_addr,
  input  logic [7:0]      cmd_len,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [63:0]     rsp_rdata,
  output logic [1:0]      rsp_resp,
  output logic            rsp_last,
  output logic            rsp_err,
  output logic            arvalid,
  input  logic            arready,
  output logic [31:0]     araddr,
  output logic [TAGW-1:0] arid,
  output logic [7:0]      arlen,
  output logic [1:0]      arburst,
  output logic [2:0]      arsize,
  input  logic            rvalid,
  output logic            rready,
  input  logic [63:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic [TAGW-1:0] rid,
  input  logic            rlast
);

  localparam int TCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // The abort is launched on the edge where the idle count would reach TIMEOUT-1.
  localparam logic [TCW-1:0] TLIM = TCW'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            arvalid_q, arvalid_d;
  logic [31:0]     araddr_q, araddr_d;
  logic [7:0]      arlen_q, arlen_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [7:0]      beat_cnt_q, beat_cnt_d;
  logic [TCW-1:0]  tcnt_q, tcnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [63:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;
  logic            rsp_last_q, rsp_last_d;
  logic            rsp_err_q, rsp_err_d;

  logic w_stall, w_beat, w_last_beat, w_tmo;
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^cmd_addr[2:0];

  assign cmd_ready   = (state_q == S_IDLE);
  assign rready      = (state_q == S_DATA) && (!rsp_valid_q || rsp_ready);
  assign w_stall     = rsp_valid_q && !rsp_ready;
  assign w_beat      = rvalid && rready;
  assign w_last_beat = (beat_cnt_q == 8'd0);
  assign w_tmo       = (tcnt_q == TLIM);

  assign arvalid   = arvalid_q;
  assign araddr    = araddr_q;
  assign arid      = tag_q;
  assign arlen     = arlen_q;
  assign arburst   = 2'b01;
  assign arsize    = 3'b011;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    tag_d       = tag_q;
    beat_cnt_d  = beat_cnt_q;
    tcnt_d      = tcnt_q;
    rsp_valid_d = rsp_valid_q && !rsp_ready;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_last_d  = rsp_last_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        tcnt_d = '0;
        if (cmd_valid) begin
          araddr_d   = {cmd_addr[31:3], 3'b000};
          arlen_d    = cmd_len;
          beat_cnt_d = cmd_len;
          arvalid_d  = 1'b1;
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        if (arvalid_q && arready) begin
          arvalid_d = 1'b0;
          tcnt_d    = '0;
          state_d   = S_DATA;
        end else if (!w_stall) begin
          if (w_tmo) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_resp_d  = 2'b10;
            rsp_last_d  = 1'b1;
            rsp_err_d   = 1'b1;
            arvalid_d   = 1'b0;
            tag_d       = tag_q + 1'b1;
            tcnt_d      = '0;
            state_d     = S_IDLE;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (w_beat) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rdata;
          rsp_resp_d  = rresp;
          rsp_last_d  = w_last_beat;
          rsp_err_d   = (rid != tag_q) || (rlast != w_last_beat);
          beat_cnt_d  = beat_cnt_q - 8'd1;
          tcnt_d      = '0;
          if (w_last_beat) begin
            tag_d   = tag_q + 1'b1;
            state_d = S_IDLE;
          end
        end else if (!w_stall) begin
          // Timer only advances while the output register could take the abort beat.
          if (w_tmo) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_resp_d  = 2'b10;
            rsp_last_d  = 1'b1;
            rsp_err_d   = 1'b1;
            tag_d       = tag_q + 1'b1;
            tcnt_d      = '0;
            state_d     = S_IDLE;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= S_IDLE;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      tag_q       <= '0;
      beat_cnt_q  <= '0;
      tcnt_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      tag_q       <= tag_d;
      beat_cnt_q  <= beat_cnt_d;
      tcnt_q      <= tcnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_last_q  <= rsp_last_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule
`default_nettype wire
